btf_sched: RTL and testbench

BTF_SCHED -- requirements
Module: btf_sched

---
 rtl/btf_sched_pkg.sv | 16 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/btf_sched.sv | 122 ++++++++++++
 tb/tb_btf_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btf_sched_pkg.sv
// Shared NTT scheduler definitions: default coefficient width, butterfly
// mode constants and the scheduler state encoding.
package btf_sched_pkg;

  localparam int unsigned LOGQ_DEF = 32;

  localparam logic BTF_GS = 1'b1;
  localparam logic BTF_CT = 1'b0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } sched_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: rd_data always presents the oldest entry,
// and stays stable until rd_en pops it.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  // Qualify requests and advance pointers / occupancy.
  always_comb begin
    do_wr    = wr_en && (count_q != (AW+1)'(DEPTH));
    do_rd    = rd_en && (count_q != '0);
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/btf_sched.sv
// Butterfly scheduler: feeds operands to a fixed-latency butterfly core,
// tracks in-flight beats with a valid chain, buffers results in a FIFO and
// drains the pipeline before any CT/GS mode change.
module btf_sched #(
  parameter int unsigned LOGQ        = btf_sched_pkg::LOGQ_DEF,
  parameter int unsigned DELAY_TOTAL = 8,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mode,
  input  logic [LOGQ-1:0] in_a,
  input  logic [LOGQ-1:0] in_b,
  input  logic [LOGQ-1:0] in_w,
  output logic            btf_gs,
  output logic [LOGQ-1:0] btf_in_a,
  output logic [LOGQ-1:0] btf_in_b,
  output logic [LOGQ-1:0] btf_in_w,
  input  logic [LOGQ-1:0] btf_out_a,
  input  logic [LOGQ-1:0] btf_out_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGQ-1:0] out_a,
  output logic [LOGQ-1:0] out_b,
  output logic            busy
);

  import btf_sched_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  sched_state_e     state_q, state_d;
  logic             btf_gs_q, btf_gs_d;
  logic [LOGQ-1:0]  a_q, a_d, b_q, b_d, w_q, w_d;
  logic [DELAY_TOTAL:0] vchain_q, vchain_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      occupancy;
  logic             fifo_empty;
  logic             accept, tail, rd_en;

  // Inflight beats plus buffered results must never exceed FIFO capacity,
  // so every chain tail is guaranteed a free FIFO slot.
  always_comb begin
    occupancy = {1'b0, inflight_q} + {1'b0, fifo_count};
    in_ready  = (state_q == RUN) && (occupancy < (CW+1)'(FIFO_DEPTH))
                && (in_mode == btf_gs_q);
    accept    = in_valid && in_ready;
    tail      = vchain_q[DELAY_TOTAL];
    rd_en     = out_valid && out_ready;
  end

  // Operand capture, valid chain and inflight tracking.
  always_comb begin
    a_d        = accept ? in_a : a_q;
    b_d        = accept ? in_b : b_q;
    w_d        = accept ? in_w : w_q;
    vchain_d   = {vchain_q[DELAY_TOTAL-1:0], accept};
    inflight_d = inflight_q + CW'(accept) - CW'(tail);
  end

  // Mode FSM: a mode mismatch stops acceptance, waits for the pipe to
  // empty, then latches the new mode in SWITCH.
  always_comb begin
    state_d  = state_q;
    btf_gs_d = btf_gs_q;
    unique case (state_q)
      RUN:     if (in_valid && (in_mode != btf_gs_q)) state_d = DRAIN;
      DRAIN:   if (inflight_q == '0) state_d = SWITCH;
      SWITCH: begin
        btf_gs_d = in_mode;
        state_d  = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // State, mode, operand and tracking registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      btf_gs_q   <= BTF_CT;
      a_q        <= '0;
      b_q        <= '0;
      w_q        <= '0;
      vchain_q   <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      btf_gs_q   <= btf_gs_d;
      a_q        <= a_d;
      b_q        <= b_d;
      w_q        <= w_d;
      vchain_q   <= vchain_d;
      inflight_q <= inflight_d;
    end
  end

  sync_fifo #(
    .WIDTH (2*LOGQ),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tail),
    .wr_data ({btf_out_a, btf_out_b}),
    .rd_en   (rd_en),
    .rd_data ({out_a, out_b}),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign btf_gs    = btf_gs_q;
  assign btf_in_a  = a_q;
  assign btf_in_b  = b_q;
  assign btf_in_w  = w_q;
  assign busy      = (inflight_q != '0) || (fifo_count != '0) || (state_q != RUN);

endmodule

// File: tb/tb_btf_sched.sv
// Bench for btf_sched with a behavioural q=17 butterfly core of latency 8.
module tb_btf_sched;
  import btf_sched_pkg::*;

  localparam int unsigned LOGQ = 32;
  localparam int unsigned DT   = 8;
  localparam int unsigned FD   = 16;
  localparam longint      Q    = 17;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, in_mode;
  logic [LOGQ-1:0] in_a, in_b, in_w;
  logic            btf_gs;
  logic [LOGQ-1:0] btf_in_a, btf_in_b, btf_in_w;
  logic [LOGQ-1:0] btf_out_a, btf_out_b;
  logic            out_valid, out_ready;
  logic [LOGQ-1:0] out_a, out_b;
  logic            busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [2*LOGQ-1:0] sb_q [$];

  btf_sched #(.LOGQ(LOGQ), .DELAY_TOTAL(DT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .in_w(in_w),
    .btf_gs(btf_gs), .btf_in_a(btf_in_a), .btf_in_b(btf_in_b), .btf_in_w(btf_in_w),
    .btf_out_a(btf_out_a), .btf_out_b(btf_out_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CT: (a + wb, a - wb); GS: (a + b, (a - b) w), all mod 17.
  function automatic logic [2*LOGQ-1:0] btf_ref(input logic gs, input logic [LOGQ-1:0] a,
                                                input logic [LOGQ-1:0] b, input logic [LOGQ-1:0] w);
    longint x, y, z, t, ra, rb;
    x = longint'(a) % Q;
    y = longint'(b) % Q;
    z = longint'(w) % Q;
    if (gs) begin
      ra = (x + y) % Q;
      rb = (((x - y + Q) % Q) * z) % Q;
    end else begin
      t  = (z * y) % Q;
      ra = (x + t) % Q;
      rb = (x - t + Q) % Q;
    end
    return {LOGQ'(ra), LOGQ'(rb)};
  endfunction

  // Butterfly core model: DT-stage pipeline from btf_in_* to btf_out_*.
  logic [2*LOGQ-1:0] core_pipe [DT];
  always @(posedge clk) begin
    core_pipe[0] <= btf_ref(btf_gs, btf_in_a, btf_in_b, btf_in_w);
    for (int i = 1; i < int'(DT); i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign {btf_out_a, btf_out_b} = core_pipe[DT-1];

  // One cycle of stimulus; records handshakes and pushes expected results.
  task automatic drive_cycle(input logic v, input logic m, input logic [LOGQ-1:0] a,
                             input logic [LOGQ-1:0] b, input logic [LOGQ-1:0] w, input logic rdy,
                             output logic acc, output logic got,
                             output logic [LOGQ-1:0] oa, output logic [LOGQ-1:0] ob);
    @(negedge clk);
    in_valid = v; in_mode = m; in_a = a; in_b = b; in_w = w; out_ready = rdy;
    #1;
    acc = in_valid && in_ready;
    got = out_valid && out_ready;
    oa  = out_a;
    ob  = out_b;
    if (acc) sb_q.push_back(btf_ref(m, a, b, w));
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_mode = BTF_CT; in_a = '0; in_b = '0; in_w = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (btf_gs !== 1'b0) begin errors++; $display("FAIL reset_btf_gs: got %b want 0", btf_gs); end
    checks++; if ({btf_in_a, btf_in_b, btf_in_w} !== '0) begin
      errors++; $display("FAIL reset_btf_in: got %h %h %h want 0", btf_in_a, btf_in_b, btf_in_w); end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_ct();
    logic acc, got; logic [LOGQ-1:0] oa, ob; logic [2*LOGQ-1:0] exp;
    int n, acc_cyc;
    acc = 1'b0; got = 1'b0; n = 0;
    while (!acc && n < 20) begin drive_cycle(1'b1, BTF_CT, 32'd3, 32'd5, 32'd2, 1'b1, acc, got, oa, ob); n++; end
    acc_cyc = cyc;
    checks++; if (!acc) begin errors++; $display("FAIL ct_accept: got no acceptance want acceptance"); end
    got = 1'b0; n = 0;
    while (!got && n < 40) begin drive_cycle(1'b0, BTF_CT, '0, '0, '0, 1'b1, acc, got, oa, ob); n++; end
    checks++;
    if (!got) begin errors++; $display("FAIL ct_output: got no out_valid want out_valid"); end
    else begin
      if (cyc - acc_cyc !== int'(DT) + 2) begin
        errors++; $display("FAIL ct_latency: got %0d want %0d", cyc - acc_cyc, int'(DT) + 2); end
      checks++; if (oa !== 32'd13) begin errors++; $display("FAIL ct_out_a: got %0d want 13", oa); end
      checks++; if (ob !== 32'd10) begin errors++; $display("FAIL ct_out_b: got %0d want 10", ob); end
      exp = sb_q.pop_front();
    end
  endtask

  task automatic test_gs();
    logic acc, got; logic [LOGQ-1:0] oa, ob; logic [2*LOGQ-1:0] exp;
    int n;
    acc = 1'b0; got = 1'b0; n = 0;
    while (!acc && n < 20) begin drive_cycle(1'b1, BTF_GS, 32'd3, 32'd5, 32'd2, 1'b1, acc, got, oa, ob); n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL gs_switch_wait: got accept on cycle %0d want 4", n); end
    checks++; if (btf_gs !== 1'b1) begin errors++; $display("FAIL gs_mode: got %b want 1", btf_gs); end
    got = 1'b0; n = 0;
    while (!got && n < 40) begin drive_cycle(1'b0, BTF_GS, '0, '0, '0, 1'b1, acc, got, oa, ob); n++; end
    checks++;
    if (!got) begin errors++; $display("FAIL gs_output: got no out_valid want out_valid"); end
    else begin
      exp = sb_q.pop_front();
      if ({oa, ob} !== exp) begin errors++; $display("FAIL gs_scoreboard: got %0d,%0d want %0d,%0d", oa, ob, exp[2*LOGQ-1:LOGQ], exp[LOGQ-1:0]); end
      checks++; if ({oa, ob} !== {32'd8, 32'd13}) begin errors++; $display("FAIL gs_value: got %0d,%0d want 8,13", oa, ob); end
    end
  endtask

  task automatic test_backpressure();
    logic acc, got; logic [LOGQ-1:0] oa, ob, a, b, w; logic [2*LOGQ-1:0] exp;
    int n, sent, stall_at, popped;
    sent = 0; stall_at = -1; popped = 0;
    a = $urandom_range(0, 16); b = $urandom_range(0, 16); w = $urandom_range(0, 16);
    for (n = 0; n < 60; n++) begin
      drive_cycle(1'b1, BTF_CT, a, b, w, 1'b0, acc, got, oa, ob);
      if (acc) begin
        sent++;
        a = $urandom_range(0, 16); b = $urandom_range(0, 16); w = $urandom_range(0, 16);
      end else if (btf_gs === 1'b0 && stall_at < 0) stall_at = sent;
    end
    checks++; if (stall_at !== int'(FD)) begin errors++; $display("FAIL bp_stall_point: got %0d want %0d", stall_at, FD); end
    checks++; if (sent !== int'(FD)) begin errors++; $display("FAIL bp_held: got %0d accepted want %0d", sent, FD); end
    checks++; if (out_valid !== 1'b1 || {out_a, out_b} !== sb_q[0]) begin
      errors++; $display("FAIL bp_show_ahead: got v=%b %0d,%0d want v=1 head", out_valid, out_a, out_b); end
    n = 0;
    while (popped < 20 && n < 300) begin
      drive_cycle(sent < 20, BTF_CT, a, b, w, 1'b1, acc, got, oa, ob);
      if (acc) begin
        sent++;
        a = $urandom_range(0, 16); b = $urandom_range(0, 16); w = $urandom_range(0, 16);
      end
      if (got) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL bp_extra_out: got %0d,%0d want none", oa, ob); end
        else begin
          exp = sb_q.pop_front();
          if ({oa, ob} !== exp) begin errors++; $display("FAIL bp_result %0d: got %0d,%0d want %0d,%0d", popped, oa, ob, exp[2*LOGQ-1:LOGQ], exp[LOGQ-1:0]); end
        end
        popped++;
      end
      n++;
    end
    checks++; if (popped !== 20) begin errors++; $display("FAIL bp_count: got %0d want 20", popped); end
  endtask

  task automatic test_mode_change();
    logic acc, got; logic [LOGQ-1:0] oa, ob; logic [2*LOGQ-1:0] exp;
    logic [LOGQ-1:0] va [5]; logic [LOGQ-1:0] vb [5]; logic [LOGQ-1:0] vw [5]; logic vm [5];
    int n, idx, popped, last_ct, rise;
    for (int i = 0; i < 5; i++) begin
      va[i] = $urandom_range(0, 16); vb[i] = $urandom_range(0, 16); vw[i] = $urandom_range(0, 16);
      vm[i] = (i == 4) ? BTF_GS : BTF_CT;
    end
    idx = 0; popped = 0; last_ct = -1; rise = -1; n = 0;
    while (popped < 5 && n < 200) begin
      if (idx < 5) drive_cycle(1'b1, vm[idx], va[idx], vb[idx], vw[idx], 1'b1, acc, got, oa, ob);
      else         drive_cycle(1'b0, BTF_GS, '0, '0, '0, 1'b1, acc, got, oa, ob);
      if (acc) begin
        if (idx == 3) last_ct = cyc;
        idx++;
      end
      if (btf_gs === 1'b1 && rise < 0) rise = cyc;
      if (got) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL mc_extra_out: got %0d,%0d want none", oa, ob); end
        else begin
          exp = sb_q.pop_front();
          if ({oa, ob} !== exp) begin errors++; $display("FAIL mc_result %0d: got %0d,%0d want %0d,%0d", popped, oa, ob, exp[2*LOGQ-1:LOGQ], exp[LOGQ-1:0]); end
        end
        popped++;
      end
      n++;
    end
    checks++; if (popped !== 5) begin errors++; $display("FAIL mc_count: got %0d want 5", popped); end
    checks++; if (rise - last_ct !== int'(DT) + 4) begin
      errors++; $display("FAIL mc_gs_rise: got %0d cycles after last CT want %0d", rise - last_ct, int'(DT) + 4); end
  endtask

  task automatic test_reset_midflight();
    logic acc, got; logic [LOGQ-1:0] oa, ob; logic [2*LOGQ-1:0] exp;
    int n, sent, seen, acc_cyc;
    sent = 0; n = 0;
    while (sent < 3 && n < 20) begin
      drive_cycle(1'b1, btf_gs, 32'd1 + LOGQ'(sent), 32'd4, 32'd6, 1'b1, acc, got, oa, ob);
      if (acc) sent++;
      n++;
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_clear: got busy=%b out_valid=%b want 0,0", busy, out_valid); end
    @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b0, BTF_CT, '0, '0, '0, 1'b1, acc, got, oa, ob);
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_ghost: got %0d out_valid cycles want 0", seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin drive_cycle(1'b1, BTF_CT, 32'd7, 32'd9, 32'd4, 1'b1, acc, got, oa, ob); n++; end
    acc_cyc = cyc;
    got = 1'b0; n = 0;
    while (!got && n < 40) begin drive_cycle(1'b0, BTF_CT, '0, '0, '0, 1'b1, acc, got, oa, ob); n++; end
    checks++;
    if (!got || sb_q.size() == 0) begin errors++; $display("FAIL rst_mid_next: got no result want one"); end
    else begin
      exp = sb_q.pop_front();
      if ({oa, ob} !== {32'd9, 32'd5} || {oa, ob} !== exp) begin
        errors++; $display("FAIL rst_mid_value: got %0d,%0d want 9,5", oa, ob); end
      checks++; if (cyc - acc_cyc !== int'(DT) + 2) begin
        errors++; $display("FAIL rst_mid_latency: got %0d want %0d", cyc - acc_cyc, int'(DT) + 2); end
    end
  endtask

  initial begin
    test_reset();
    test_ct();
    test_gs();
    test_backpressure();
    test_mode_change();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
